gpio_port: RTL

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_port.sv | 102 ++++++++++
 1 files changed

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - GPIO port with direction control, synchronized inputs, rising-edge status and interrupt
module gpio_port #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rstb,
    input  logic             i_clk_en,
    input  logic [2:0]       i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_wr,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rvalid,
    output logic             o_irq,
    inout  wire  [WIDTH-1:0] io_gpio
);

    localparam logic [2:0] ADDR_OUT   = 3'd0;
    localparam logic [2:0] ADDR_DIR   = 3'd1;
    localparam logic [2:0] ADDR_IN    = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;
    localparam logic [2:0] ADDR_IRQEN = 3'd4;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] irqen_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] prev_q;
    logic [1:0]       settle_q;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] rd_mux;
    logic             settled;

    genvar g;
    for (g = 0; g < WIDTH; g++) begin : g_pin
        assign io_gpio[g] = dir_q[g] ? out_q[g] : 1'bz;
    end

    // Set wins over clear: the new rise is OR-ed in after the W1C mask.
    always_comb begin
        settled   = (settle_q == 2'd3);
        rise      = in_q & ~prev_q;
        w1c       = (i_wr && (i_addr == ADDR_EDGE)) ? i_wdata : '0;
        edge_next = (edge_q & ~w1c) | (settled ? rise : '0);
    end

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_OUT:   rd_mux = out_q;
            ADDR_DIR:   rd_mux = dir_q;
            ADDR_IN:    rd_mux = in_q;
            ADDR_EDGE:  rd_mux = edge_q;
            ADDR_IRQEN: rd_mux = irqen_q;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            out_q    <= '0;
            dir_q    <= '0;
            edge_q   <= '0;
            irqen_q  <= '0;
            sync_q   <= '0;
            in_q     <= '0;
            prev_q   <= '0;
            settle_q <= 2'd0;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
            o_irq    <= 1'b0;
        end else if (i_clk_en) begin
            sync_q   <= io_gpio;
            in_q     <= sync_q;
            prev_q   <= in_q;
            if (!settled) begin
                settle_q <= settle_q + 2'd1;
            end
            edge_q   <= edge_next;
            o_irq    <= |(edge_q & irqen_q);
            o_rvalid <= i_rd;
            // Read samples current contents, so a same-cycle write is not visible yet.
            if (i_rd) begin
                o_rdata <= rd_mux;
            end
            if (i_wr) begin
                case (i_addr)
                    ADDR_OUT:   out_q   <= i_wdata;
                    ADDR_DIR:   dir_q   <= i_wdata;
                    ADDR_IRQEN: irqen_q <= i_wdata;
                    default:    ;
                endcase
            end
        end
    end

endmodule
